// File: rtl/tick_divider_pkg.sv
// Shared register map, CTRL bit layout and control struct for the tick divider bank.
package tick_divider_pkg;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_MAX0    = 4'd1;
  localparam logic [3:0] REG_MAX1    = 4'd2;
  localparam logic [3:0] REG_MAX2    = 4'd3;
  localparam logic [3:0] REG_MAX3    = 4'd4;
  localparam logic [3:0] REG_STATUS  = 4'd5;
  localparam logic [3:0] REG_FLAGCLR = 4'd6;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;
  localparam int unsigned CTRL_INVERT_BIT  = 2;

  localparam int unsigned MAX_BYTES = 4;

  typedef struct packed {
    logic invert;
    logic oneshot;
    logic en;
  } ch_ctrl_t;

  function automatic ch_ctrl_t ctrl_from_byte(input logic [7:0] b);
    ch_ctrl_t c;
    c.en      = b[CTRL_EN_BIT];
    c.oneshot = b[CTRL_ONESHOT_BIT];
    c.invert  = b[CTRL_INVERT_BIT];
    return c;
  endfunction

  function automatic logic [7:0] ctrl_to_byte(input ch_ctrl_t c);
    logic [7:0] b;
    b                   = 8'h00;
    b[CTRL_EN_BIT]      = c.en;
    b[CTRL_ONESHOT_BIT] = c.oneshot;
    b[CTRL_INVERT_BIT]  = c.invert;
    return b;
  endfunction

endpackage

// File: rtl/tick_divider_chan.sv
// One divider channel: counter, shadow/active period, toggle, tick pulse and sticky flag.
// The sticky terminal flag exists only when TICK_IRQ_EN is defined.
module tick_divider_chan
  import tick_divider_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH = 26,
  parameter logic [CNT_WIDTH-1:0] RST_MAX   = '0,
  parameter bit                   RST_EN    = 1'b0
) (
  input  logic                  clk24,
  input  logic                  rst_f,
  input  logic                  pre_en,
  input  logic                  wr_ctrl,
  input  logic [MAX_BYTES-1:0]  wr_max,
  input  logic                  wr_flagclr,
  input  logic [7:0]            wdata,
  output ch_ctrl_t              ctrl_o,
  output logic [CNT_WIDTH-1:0]  shadow_o,
  output logic                  toggle_o,
  output logic                  tick_o,
  output logic                  clk_o,
  output logic                  flag_o,
  output logic                  flag_nxt_c
);

  ch_ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_WIDTH-1:0] active_q, active_d;
  logic                 toggle_q, toggle_d;
  logic                 tick_q;
  logic                 clk_q, clk_d;
  logic                 term_c;
  logic [31:0]          shadow_w;

  // Byte-lane merge of MAX writes; bits above CNT_WIDTH are dropped.
  always_comb begin
    shadow_w = 32'(shadow_q);
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (wr_max[b]) shadow_w[8*b +: 8] = wdata;
    end
    shadow_d = CNT_WIDTH'(shadow_w);
  end

  assign term_c = ctrl_q.en && pre_en && (cnt_q == active_q);

  always_comb begin
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (wr_ctrl) ctrl_d = ctrl_from_byte(wdata);
    if (term_c) begin
      cnt_d = '0;
      if (ctrl_q.oneshot) ctrl_d.en = 1'b0;
    end else if (ctrl_q.en && pre_en) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    // A disabled channel (by write or one-shot) always parks at zero.
    if (!ctrl_d.en) cnt_d = '0;
    if (term_c || !ctrl_q.en) active_d = shadow_d;
    toggle_d = toggle_q ^ term_c;
    clk_d    = toggle_d ^ ctrl_d.invert;
  end

  always_ff @(posedge clk24 or posedge rst_f) begin
    if (rst_f) begin
      ctrl_q   <= ch_ctrl_t'{invert: 1'b0, oneshot: 1'b0, en: RST_EN};
      cnt_q    <= '0;
      shadow_q <= RST_MAX;
      active_q <= RST_MAX;
      toggle_q <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      toggle_q <= toggle_d;
      tick_q   <= term_c;
      clk_q    <= clk_d;
    end
  end

`ifdef TICK_IRQ_EN
  logic flag_q, flag_d;

  // Set dominates a coincident clear.
  assign flag_d = term_c | (flag_q & ~(wr_flagclr & wdata[0]));

  always_ff @(posedge clk24 or posedge rst_f) begin
    if (rst_f) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign flag_o     = flag_q;
  assign flag_nxt_c = flag_d;
`else
  logic unused_flagclr;
  assign unused_flagclr = wr_flagclr;
  assign flag_o         = 1'b0;
  assign flag_nxt_c     = 1'b0;
`endif

  assign ctrl_o   = ctrl_q;
  assign shadow_o = shadow_q;
  assign toggle_o = toggle_q;
  assign tick_o   = tick_q;
  assign clk_o    = clk_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Multi-channel programmable tick/debug-clock generator with an 8-bit register port.
// Optional sticky terminal flags and irq_o are built when TICK_IRQ_EN is defined.
module tick_divider_bank
  import tick_divider_pkg::*;
#(
  parameter int unsigned          CHANNELS    = 4,
  parameter int unsigned          CNT_WIDTH   = 26,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_MAX = CNT_WIDTH'(6000000),
  parameter int unsigned          PRESCALE    = 2
) (
  input  logic                clk24,
  input  logic                rst_f,
  input  logic                ext_wr,
  input  logic                ext_rd,
  input  logic [7:0]          ext_ad,
  input  logic [7:0]          ext_di,
  output logic [7:0]          ext_do,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] clk_o,
  output logic                irq_o
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic                 pre_en_c;
  logic [7:0]           ext_do_q, ext_do_d;
  logic [7:0]           rd_data_c;
  logic [31:0]          max_w;
  logic [3:0]           ch_sel_c, reg_sel_c;
  ch_ctrl_t             ch_ctrl  [CHANNELS];
  logic [CNT_WIDTH-1:0] ch_max   [CHANNELS];
  logic [CHANNELS-1:0]  ch_toggle, ch_flag, ch_flag_nxt;

  assign ch_sel_c  = ext_ad[7:4];
  assign reg_sel_c = ext_ad[3:0];

  // Free-running common prescaler; never restarted by channel enables.
  assign pre_en_c  = (pre_cnt_q == PRE_W'(PRESCALE - 1));
  assign pre_cnt_d = pre_en_c ? '0 : pre_cnt_q + PRE_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic                 hit_c;
    logic [MAX_BYTES-1:0] wr_max_c;

    assign hit_c = ext_wr && (ch_sel_c == 4'(i));

    always_comb begin
      wr_max_c = '0;
      for (int b = 0; b < MAX_BYTES; b++) begin
        wr_max_c[b] = hit_c && (reg_sel_c == REG_MAX0 + 4'(b));
      end
    end

    tick_divider_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .RST_MAX   ((i == 0) ? DEFAULT_MAX : '0),
      .RST_EN    (i == 0)
    ) u_chan (
      .clk24      (clk24),
      .rst_f      (rst_f),
      .pre_en     (pre_en_c),
      .wr_ctrl    (hit_c && (reg_sel_c == REG_CTRL)),
      .wr_max     (wr_max_c),
      .wr_flagclr (hit_c && (reg_sel_c == REG_FLAGCLR)),
      .wdata      (ext_di),
      .ctrl_o     (ch_ctrl[i]),
      .shadow_o   (ch_max[i]),
      .toggle_o   (ch_toggle[i]),
      .tick_o     (tick_o[i]),
      .clk_o      (clk_o[i]),
      .flag_o     (ch_flag[i]),
      .flag_nxt_c (ch_flag_nxt[i])
    );
  end

  // Read mux; unmapped registers and absent channels return zero.
  always_comb begin
    rd_data_c = 8'h00;
    max_w     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel_c == 4'(i)) begin
        max_w = 32'(ch_max[i]);
        case (reg_sel_c)
          REG_CTRL:   rd_data_c = ctrl_to_byte(ch_ctrl[i]);
          REG_MAX0:   rd_data_c = max_w[7:0];
          REG_MAX1:   rd_data_c = max_w[15:8];
          REG_MAX2:   rd_data_c = max_w[23:16];
          REG_MAX3:   rd_data_c = max_w[31:24];
          REG_STATUS: rd_data_c = {5'b0, ch_flag[i], ch_ctrl[i].en, ch_toggle[i]};
          default:    rd_data_c = 8'h00;
        endcase
      end
    end
    ext_do_d = ext_rd ? rd_data_c : ext_do_q;
  end

  always_ff @(posedge clk24 or posedge rst_f) begin
    if (rst_f) begin
      pre_cnt_q <= '0;
      ext_do_q  <= 8'h00;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      ext_do_q  <= ext_do_d;
    end
  end

`ifdef TICK_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk24 or posedge rst_f) begin
    if (rst_f) irq_q <= 1'b0;
    else       irq_q <= |ch_flag_nxt;
  end

  assign irq_o = irq_q;
`else
  logic unused_flag_nxt;
  assign unused_flag_nxt = ^ch_flag_nxt;
  assign irq_o           = 1'b0;
`endif

  assign ext_do = ext_do_q;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank (DEFAULT_MAX=3, PRESCALE=2); adapts to TICK_IRQ_EN.
module tb_tick_divider_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 26;
`ifdef TICK_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  typedef struct {
    bit         wr;
    logic [7:0] ad;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  logic          clk24 = 1'b0;
  logic          rst_f;
  logic          ext_wr, ext_rd;
  logic [7:0]    ext_ad, ext_di, ext_do;
  logic [CH-1:0] tick_o, clk_o;
  logic          irq_o;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] sb_q[$];
  vec_t       tbl[$];

  tick_divider_bank #(
    .CHANNELS    (CH),
    .CNT_WIDTH   (CW),
    .DEFAULT_MAX (26'd3),
    .PRESCALE    (2)
  ) dut (
    .clk24  (clk24),
    .rst_f  (rst_f),
    .ext_wr (ext_wr),
    .ext_rd (ext_rd),
    .ext_ad (ext_ad),
    .ext_di (ext_di),
    .ext_do (ext_do),
    .tick_o (tick_o),
    .clk_o  (clk_o),
    .irq_o  (irq_o)
  );

  always #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk24);
    @(negedge clk24);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic reg_wr(input logic [7:0] ad, input logic [7:0] di);
    ext_wr = 1'b1;
    ext_ad = ad;
    ext_di = di;
    step();
    ext_wr = 1'b0;
  endtask

  // Expected read data is queued at issue and retired once ext_do has updated.
  task automatic reg_rd(input string nm, input logic [7:0] ad, input logic [7:0] exp);
    logic [7:0] e;
    ext_rd = 1'b1;
    ext_ad = ad;
    sb_q.push_back(exp);
    step();
    ext_rd = 1'b0;
    e = sb_q.pop_front();
    check(nm, 32'(ext_do), 32'(e));
  endtask

  task automatic wait_tick(input int ch, input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound && t < 0; i++) begin
      step();
      if (tick_o[ch]) t = cyc;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic count_ticks(input int ch, input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tick_o[ch]) k++;
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [7:0] ad, input logic [7:0] di,
                              input logic [7:0] exp);
    vec_t v;
    v.wr = wr; v.ad = ad; v.di = di; v.exp = exp;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0, t, tprev, e, k, n_tk0;
    logic [7:0] st0;

    rst_f = 1'b1; ext_wr = 1'b0; ext_rd = 1'b0; ext_ad = 8'h00; ext_di = 8'h00;
    repeat (3) @(negedge clk24);
    check("rst_tick", 32'(tick_o), 32'(0));
    check("rst_clk", 32'(clk_o), 32'(0));
    check("rst_do", 32'(ext_do), 32'(0));
    check("rst_irq", 32'(irq_o), 32'(0));
    rst_f = 1'b0;
    c0 = cyc;

    // Default channel 0: MAX=3, prescale 2 -> 8-cycle terminal period.
    wait_tick(0, 40, t);
    check("t1_first_tick", 32'(t), 32'(c0 + 8));
    check("t1_clk_high", 32'(clk_o[0]), 32'(1));
    step();
    check("t1_tick_width", 32'(tick_o[0]), 32'(0));
    tprev = t;
    wait_tick(0, 40, t);
    check("t1_period", 32'(t - tprev), 32'(8));
    check("t1_clk_low", 32'(clk_o[0]), 32'(0));
    n_tk0 = 2;

    // Shadowed MAX: current period finishes at 3, following one uses 9.
    reg_wr(8'h01, 8'h09);
    tprev = t;
    wait_tick(0, 40, t);
    check("t3_old_period", 32'(t - tprev), 32'(8));
    tprev = t;
    wait_tick(0, 60, t);
    check("t3_new_period", 32'(t - tprev), 32'(20));
    n_tk0 += 2;
    wait_until(t + 19);
    reg_wr(8'h01, 8'h03);
    check("t3_term_tick", 32'(tick_o[0]), 32'(1));
    n_tk0++;
    tprev = cyc;
    wait_tick(0, 40, t);
    check("t3_wr_at_term", 32'(t - tprev), 32'(8));
    n_tk0++;

    // Disable coincident with terminal count.
    wait_until(t + 7);
    reg_wr(8'h00, 8'h00);
    check("t4_tick", 32'(tick_o[0]), 32'(1));
    n_tk0++;
    check("t4_clk", 32'(clk_o[0]), 32'(n_tk0 & 1));
    count_ticks(0, 30, k);
    check("t4_no_ticks", 32'(k), 32'(0));
    check("t4_clk_hold", 32'(clk_o[0]), 32'(n_tk0 & 1));

    // Register map table.
    st0 = {5'b0, HAS_IRQ, 1'b0, 1'(n_tk0 & 1)};
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h05, 8'h00, st0));
    tbl.push_back(mk(1'b1, 8'h01, 8'hAB, 8'h00));
    tbl.push_back(mk(1'b1, 8'h02, 8'hCD, 8'h00));
    tbl.push_back(mk(1'b1, 8'h03, 8'hEF, 8'h00));
    tbl.push_back(mk(1'b1, 8'h04, 8'hFF, 8'h00));
    tbl.push_back(mk(1'b0, 8'h01, 8'h00, 8'hAB));
    tbl.push_back(mk(1'b0, 8'h02, 8'h00, 8'hCD));
    tbl.push_back(mk(1'b0, 8'h03, 8'h00, 8'hEF));
    tbl.push_back(mk(1'b0, 8'h04, 8'h00, 8'h03));
    tbl.push_back(mk(1'b1, 8'h00, 8'hFE, 8'h00));
    tbl.push_back(mk(1'b0, 8'h00, 8'h00, 8'h06));
    tbl.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h06, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h07, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h0F, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h11, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h15, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 8'h41, 8'h55, 8'h00));
    tbl.push_back(mk(1'b0, 8'h41, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h40, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 8'h01, 8'h03, 8'h00));
    tbl.push_back(mk(1'b1, 8'h02, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 8'h03, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 8'h04, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h04, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 8'h01, 8'h00, 8'h03));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) reg_wr(tbl[i].ad, tbl[i].di);
      else reg_rd($sformatf("tbl[%0d] ad=%02h", i, tbl[i].ad), tbl[i].ad, tbl[i].exp);
    end
    repeat (3) step();
    check("rd_hold", 32'(ext_do), 32'(8'h03));

    // Invert bit on a parked channel.
    reg_wr(8'h00, 8'h04);
    check("inv_on", 32'(clk_o[0]), 32'(~n_tk0 & 1));
    reg_wr(8'h00, 8'h00);
    check("inv_off", 32'(clk_o[0]), 32'(n_tk0 & 1));

    // Re-enable starts from cnt=0 on the free-running prescaler phase.
    reg_wr(8'h00, 8'h01);
    e = cyc;
    wait_tick(0, 40, t);
    check("reen_first_tick", 32'(t), 32'(e + 8 - ((e - c0) & 1)));
    reg_wr(8'h00, 8'h00);

    // One-shot on channel 1.
    reg_wr(8'h11, 8'h05);
    reg_wr(8'h10, 8'h03);
    e = cyc;
    wait_tick(1, 60, t);
    check("t2_tick", 32'(t), 32'(e + 12 - ((e - c0) & 1)));
    count_ticks(1, 40, k);
    check("t2_single", 32'(k), 32'(0));
    check("t2_clk", 32'(clk_o[1]), 32'(1));
    reg_rd("t2_status", 8'h15, {5'b0, HAS_IRQ, 1'b0, 1'b1});
    reg_rd("t2_ctrl", 8'h10, 8'h02);

    // Sticky flag / irq on channel 2.
    reg_wr(8'h06, 8'h01);
    reg_wr(8'h16, 8'h01);
    check("t5_irq_clear0", 32'(irq_o), 32'(0));
    reg_wr(8'h21, 8'h01);
    reg_wr(8'h20, 8'h01);
    wait_tick(2, 20, t);
    check("t5_irq_set", 32'(irq_o), 32'(HAS_IRQ));
    wait_until(t + 3);
    reg_wr(8'h26, 8'h01);
    check("t5_coincident_tick", 32'(tick_o[2]), 32'(1));
    check("t5_set_wins", 32'(irq_o), 32'(HAS_IRQ));
    reg_wr(8'h20, 8'h00);
    check("t5_still_set", 32'(irq_o), 32'(HAS_IRQ));
    reg_wr(8'h26, 8'h01);
    check("t5_cleared", 32'(irq_o), 32'(0));
    reg_rd("t5_status", 8'h25, 8'h00);

    // Asynchronous reset mid-count.
    reg_wr(8'h31, 8'hA5);
    reg_rd("t6_do_a5", 8'h31, 8'hA5);
    reg_wr(8'h01, 8'h06);
    reg_wr(8'h00, 8'h01);
    repeat (5) step();
    #2 rst_f = 1'b1;
    #2;
    check("t6_do", 32'(ext_do), 32'(0));
    check("t6_tick", 32'(tick_o), 32'(0));
    check("t6_clk", 32'(clk_o), 32'(0));
    check("t6_irq", 32'(irq_o), 32'(0));
    @(negedge clk24);
    @(negedge clk24);
    rst_f = 1'b0;
    c0 = cyc;
    wait_tick(0, 40, t);
    check("t6_restart", 32'(t), 32'(c0 + 8));
    reg_rd("t6_ctrl", 8'h00, 8'h01);
    reg_rd("t6_max0", 8'h01, 8'h03);
    reg_rd("t6_ch3_max0", 8'h31, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
